// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: controller states and the command record.
package counter_seq_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_REPEAT_W   = 8;

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]      limit;
    logic [DEF_PRESCALE_W-1:0] prescale;
    logic [DEF_REPEAT_W-1:0]   repeat_cnt;
  } cmd_t;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Count-enable strobe generator: a down-counter that fires when it reaches zero,
// then reloads the prescale value, giving one tick every prescale+1 cycles.
module tick_gen #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] psc;

  assign tick = run && (psc == '0);

  // Loading zero makes the very first running cycle produce a tick.
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (run) begin
      if (psc == '0) psc <= prescale;
      else           psc <= psc - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a free-running period counter: starts it, strobes
// its enable, counts completed periods from its value and stops it when done or aborted.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int REPEAT_W   = DEF_REPEAT_W
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_limit,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  input  logic [REPEAT_W-1:0]   cmd_repeat,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      value,
  output logic                  start,
  output logic                  stop,
  output logic [WIDTH-1:0]      limit,
  output logic                  en,
  output logic                  busy,
  output logic                  period_done,
  output logic                  seq_done
);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      limit_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [REPEAT_W-1:0]   repeat_r;
  logic [REPEAT_W-1:0]   remaining;
  logic                  period_done_r;
  logic                  seq_done_r;
  logic                  tick;
  logic                  wrap;
  logic                  last_period;
  logic                  accept;
  logic [WIDTH-1:0]      limit_m1;

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk_a    (clk_a),
    .rst      (rst),
    .load     (state == START),
    .run      (state == RUN),
    .prescale (prescale_r),
    .tick     (tick)
  );

  // limit-1 wraps to all-ones for limit=0, so a zero limit means a full 2**WIDTH period.
  assign limit_m1    = limit_r - WIDTH'(1);
  assign wrap        = tick && (value == limit_m1);
  assign last_period = (repeat_r != '0) && (remaining == REPEAT_W'(1));
  assign accept      = (state == IDLE) && cmd_valid;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign start       = (state == START);
  assign stop        = (state == FLUSH) || (state == STOP);
  assign en          = tick;
  assign limit       = limit_r;
  assign period_done = period_done_r;
  assign seq_done    = seq_done_r;

  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH:   state_nxt = IDLE;
      IDLE:    if (cmd_valid) state_nxt = START;
      START:   state_nxt = abort ? STOP : RUN;
      RUN:     if (abort || (wrap && last_period)) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = FLUSH;
    endcase
  end

  // Reset lands in FLUSH so a counter left running across reset still gets a stop pulse.
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state         <= FLUSH;
      limit_r       <= '0;
      prescale_r    <= '0;
      repeat_r      <= '0;
      remaining     <= '0;
      period_done_r <= 1'b0;
      seq_done_r    <= 1'b0;
    end else begin
      state         <= state_nxt;
      period_done_r <= (state == RUN) && wrap;
      seq_done_r    <= (state == RUN) && wrap && last_period && !abort;
      if (accept) begin
        limit_r    <= cmd_limit;
        prescale_r <= cmd_prescale;
        repeat_r   <= cmd_repeat;
        remaining  <= cmd_repeat;
      end else if ((state == RUN) && wrap && (repeat_r != '0) && !last_period) begin
        remaining <= remaining - REPEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomised scoreboard bench for counter_sequencer with a behavioural counter attached.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int NO_ABORT = -2;

  logic        clk_a = 1'b0;
  logic        rst   = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_limit = '0;
  logic [7:0]  cmd_prescale = '0;
  logic [7:0]  cmd_repeat = '0;
  logic        abort = 1'b0;
  logic [15:0] value;
  logic        start, stop, en, busy, period_done, seq_done;
  logic [15:0] limit;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  bit   ready_prev = 1'b0;
  int   jump_at = -1;
  logic [15:0] jump_val = '0;
  logic [15:0] cnt = '0;
  logic        started = 1'b0;

  int q_start[$], q_stop[$], q_en[$], q_pd[$], q_sd[$], q_rdy[$];

  counter_sequencer dut (
    .clk_a        (clk_a),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_limit    (cmd_limit),
    .cmd_prescale (cmd_prescale),
    .cmd_repeat   (cmd_repeat),
    .abort        (abort),
    .value        (value),
    .start        (start),
    .stop         (stop),
    .limit        (limit),
    .en           (en),
    .busy         (busy),
    .period_done  (period_done),
    .seq_done     (seq_done)
  );

  always #5 clk_a = ~clk_a;

  always @(posedge clk_a) cyc <= cyc + 1;

  // Downstream counter: no reset, cleared by start, advanced by en, can be preset by the bench.
  always @(posedge clk_a) begin
    if (cyc == jump_at)  cnt <= jump_val;
    else if (start)      cnt <= '0;
    else if (en)         cnt <= (cnt == limit - 16'd1) ? 16'd0 : cnt + 16'd1;
    if (start)     started <= 1'b1;
    else if (stop) started <= 1'b0;
  end
  assign value = cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int pending();
    return q_start.size() + q_stop.size() + q_en.size() + q_pd.size() + q_sd.size() + q_rdy.size();
  endfunction

  task automatic clear_queues();
    q_start.delete(); q_stop.delete(); q_en.delete();
    q_pd.delete();    q_sd.delete();   q_rdy.delete();
  endtask

  task automatic pop_ev(input int ev, input string name);
    int  exp_c = 0;
    bit  have  = 1'b0;
    case (ev)
      0: if (q_start.size() > 0) begin exp_c = q_start.pop_front(); have = 1'b1; end
      1: if (q_stop.size()  > 0) begin exp_c = q_stop.pop_front();  have = 1'b1; end
      2: if (q_en.size()    > 0) begin exp_c = q_en.pop_front();    have = 1'b1; end
      3: if (q_pd.size()    > 0) begin exp_c = q_pd.pop_front();    have = 1'b1; end
      4: if (q_sd.size()    > 0) begin exp_c = q_sd.pop_front();    have = 1'b1; end
      default: if (q_rdy.size() > 0) begin exp_c = q_rdy.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: got pulse at cycle %0d expected none", name, cyc);
    end else begin
      chk(name, cyc, exp_c);
    end
  endtask

  // Monitor: every output pulse must match the next expected cycle for that output.
  always @(negedge clk_a) begin
    if (mon_on) begin
      if (start)                    pop_ev(0, "start_cycle");
      if (stop)                     pop_ev(1, "stop_cycle");
      if (en)                       pop_ev(2, "en_cycle");
      if (period_done)              pop_ev(3, "period_done_cycle");
      if (seq_done)                 pop_ev(4, "seq_done_cycle");
      if (cmd_ready && !ready_prev) pop_ev(5, "ready_return_cycle");
      if (start || stop) chk("start_stop_exclusive", 32'(start && stop), 0);
      chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
    end
    ready_prev = cmd_ready;
  end

  task automatic finish_cmd(input string tag);
    int n = 0;
    while (!cmd_ready && n < 4000) begin
      @(negedge clk_a);
      n++;
    end
    chk({tag, "_ready_return"}, 32'(cmd_ready), 1);
    @(posedge clk_a);
    chk({tag, "_leftover_events"}, pending(), 0);
    clear_queues();
    @(negedge clk_a);
  endtask

  // Reference: en k falls on run cycle k*P, and the counter shows k mod L there,
  // so the j-th wrap is at run cycle (j*L-1)*P; the run starts two cycles after accept.
  task automatic applyStimulus(input cmd_t c, input int ab_off, input bit ab_with_cmd);
    int n = 0;
    int a, lim_len, p, end_off, end_cyc;
    while (!cmd_ready && n < 200) begin
      @(negedge clk_a);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    if (!cmd_ready) return;
    a            = cyc;
    cmd_valid    = 1'b1;
    cmd_limit    = c.limit;
    cmd_prescale = c.prescale;
    cmd_repeat   = c.repeat_cnt;
    abort        = ab_with_cmd;
    lim_len      = (c.limit == 0) ? 65536 : int'(c.limit);
    p            = int'(c.prescale) + 1;
    q_start.push_back(a + 1);
    if (ab_off == -1) begin
      end_cyc = a + 1;
    end else begin
      end_off = (ab_off >= 0) ? ab_off : (int'(c.repeat_cnt) * lim_len - 1) * p;
      for (int k = 0; k * p <= end_off; k++) q_en.push_back(a + 2 + k * p);
      for (int j = 1; (j * lim_len - 1) * p <= end_off; j++)
        q_pd.push_back(a + 2 + (j * lim_len - 1) * p + 1);
      end_cyc = a + 2 + end_off;
    end
    q_stop.push_back(end_cyc + 1);
    if (ab_off == NO_ABORT) q_sd.push_back(end_cyc + 1);
    q_rdy.push_back(end_cyc + 2);
    @(negedge clk_a);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("limit_latched", limit, c.limit);
    if (ab_off != NO_ABORT) begin
      while (cyc < ((ab_off == -1) ? a + 1 : a + 2 + ab_off)) @(negedge clk_a);
      abort = 1'b1;
      @(negedge clk_a);
      abort = 1'b0;
    end
    finish_cmd("cmd");
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] exp_bits, input logic [15:0] exp_limit);
    chk({tag, "_stop"},        32'(stop),        32'(exp_bits[6]));
    chk({tag, "_cmd_ready"},   32'(cmd_ready),   32'(exp_bits[5]));
    chk({tag, "_busy"},        32'(busy),        32'(exp_bits[4]));
    chk({tag, "_start"},       32'(start),       32'(exp_bits[3]));
    chk({tag, "_en"},          32'(en),          32'(exp_bits[2]));
    chk({tag, "_period_done"}, 32'(period_done), 32'(exp_bits[1]));
    chk({tag, "_seq_done"},    32'(seq_done),    32'(exp_bits[0]));
    chk({tag, "_limit"},       limit,            exp_limit);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_t c;
    int   a, fo, ab;

    // Reset, release, single flush cycle with stop, then idle.
    repeat (2) @(negedge clk_a);
    checkOutput("reset", 7'b1010000, 16'd0);
    @(posedge clk_a);
    #2 rst = 1'b0;
    @(negedge clk_a);
    checkOutput("flush", 7'b1010000, 16'd0);
    @(negedge clk_a);
    checkOutput("idle", 7'b0100000, 16'd0);
    @(posedge clk_a);
    mon_on = 1'b1;
    @(negedge clk_a);

    c = '{limit: 16'd4, prescale: 8'd0, repeat_cnt: 8'd2};
    applyStimulus(c, NO_ABORT, 1'b0);
    c = '{limit: 16'd3, prescale: 8'd2, repeat_cnt: 8'd1};
    applyStimulus(c, NO_ABORT, 1'b0);
    c = '{limit: 16'd5, prescale: 8'd0, repeat_cnt: 8'd0};
    applyStimulus(c, 11, 1'b0);
    c = '{limit: 16'd2, prescale: 8'd0, repeat_cnt: 8'd1};
    applyStimulus(c, 1, 1'b0);
    c = '{limit: 16'd1, prescale: 8'd0, repeat_cnt: 8'd3};
    applyStimulus(c, NO_ABORT, 1'b1);
    c = '{limit: 16'd3, prescale: 8'd1, repeat_cnt: 8'd2};
    applyStimulus(c, -1, 1'b0);

    // limit=0: counter preset near the top so the all-ones wrap is reached quickly.
    a            = cyc;
    cmd_valid    = 1'b1;
    cmd_limit    = 16'd0;
    cmd_prescale = 8'd0;
    cmd_repeat   = 8'd1;
    jump_val     = 16'hFFF0;
    jump_at      = a + 4;
    q_start.push_back(a + 1);
    for (int o = 0; o <= 18; o++) q_en.push_back(a + 2 + o);
    q_pd.push_back(a + 21);
    q_sd.push_back(a + 21);
    q_stop.push_back(a + 21);
    q_rdy.push_back(a + 22);
    @(negedge clk_a);
    cmd_valid = 1'b0;
    finish_cmd("wrap_all_ones");

    for (int i = 0; i < 25; i++) begin
      c.limit      = 16'($urandom_range(1, 6));
      c.prescale   = 8'($urandom_range(0, 3));
      c.repeat_cnt = 8'($urandom_range(0, 3));
      fo = (int'(c.repeat_cnt) * int'(c.limit) - 1) * (int'(c.prescale) + 1);
      if (c.repeat_cnt == 0)               ab = int'($urandom_range(0, 31)) - 1;
      else if ($urandom_range(0, 3) == 0)  ab = int'($urandom_range(0, fo + 1)) - 1;
      else                                 ab = NO_ABORT;
      applyStimulus(c, ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk_a);
    end

    // Reset while running: immediate reset outputs, then a stop pulse stops the counter.
    @(posedge clk_a);
    mon_on = 1'b0;
    @(negedge clk_a);
    cmd_valid    = 1'b1;
    cmd_limit    = 16'd6;
    cmd_prescale = 8'd1;
    cmd_repeat   = 8'd0;
    @(negedge clk_a);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk_a);
    chk("midrun_started", 32'(started), 1);
    chk("midrun_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 checkOutput("midrun_reset", 7'b1010000, 16'd0);
    repeat (2) @(posedge clk_a);
    #2 rst = 1'b0;
    @(negedge clk_a);
    chk("post_reset_stop", 32'(stop), 1);
    @(negedge clk_a);
    chk("post_reset_ready", 32'(cmd_ready), 1);
    chk("post_reset_counter_started", 32'(started), 0);
    clear_queues();
    @(posedge clk_a);
    mon_on = 1'b1;
    @(negedge clk_a);
    c = '{limit: 16'd2, prescale: 8'd0, repeat_cnt: 8'd2};
    applyStimulus(c, NO_ABORT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
